// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle CPU control unit:
// FSM states, opcode map, ALU operation codes and PC-source selects.
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    STALL,
    EXEC,
    MEM,
    WB,
    HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_NOP   = 6'h3F;

  localparam logic [5:0] ALU_ADD = 6'h20;
  localparam logic [5:0] ALU_SUB = 6'h22;

  localparam logic [1:0] PC_SRC_INC  = 2'd0;
  localparam logic [1:0] PC_SRC_IMM  = 2'd1;
  localparam logic [1:0] PC_SRC_ADDR = 2'd2;

  // rt only matters for instructions that read it as a source operand
  function automatic logic hazard_hit(input logic [5:0] op,
                                      input logic       rs_busy,
                                      input logic       rt_busy);
    case (op)
      OP_RTYPE, OP_BEQ, OP_SW: hazard_hit = rs_busy | rt_busy;
      OP_ADDI, OP_LW:          hazard_hit = rs_busy;
      default:                 hazard_hit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode map: instruction-type flags, ALU operation select
// and the legal-opcode bit.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int ALU_OP_WIDTH = 6
) (
  input  logic [5:0]              i_opcode,
  input  logic [5:0]              i_funct,
  output logic                    o_is_r,
  output logic                    o_is_i,
  output logic                    o_is_j,
  output logic                    o_legal,
  output logic [ALU_OP_WIDTH-1:0] o_alu_op
);

  always_comb begin
    o_is_r   = 1'b0;
    o_is_i   = 1'b0;
    o_is_j   = 1'b0;
    o_legal  = 1'b1;
    o_alu_op = '0;
    unique case (i_opcode)
      OP_RTYPE: begin
        o_is_r   = 1'b1;
        o_alu_op = ALU_OP_WIDTH'(i_funct);
      end
      OP_ADDI, OP_LW, OP_SW: begin
        o_is_i   = 1'b1;
        o_alu_op = ALU_OP_WIDTH'(ALU_ADD);
      end
      OP_BEQ: begin
        o_is_i   = 1'b1;
        o_alu_op = ALU_OP_WIDTH'(ALU_SUB);
      end
      OP_J:    o_is_j = 1'b1;
      OP_NOP:  ;
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_fsm_cpu.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB with hazard stall and HALT.
// Optional performance counters are compiled in with `define CTRL_PERF_CNT_EN.
module control_fsm_cpu
  import ctrl_pkg::*;
#(
  parameter int STALL_LIMIT  = 15,
  parameter int ALU_OP_WIDTH = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              opcode,
  input  logic [5:0]              funct,
  input  logic                    is_alu_zero,
  input  logic                    is_full_rnum1,
  input  logic                    is_full_rnum2,
  output logic                    is_load_PC,
  output logic                    is_write_reg,
  output logic                    is_write_mem,
  output logic [ALU_OP_WIDTH-1:0] opcode_alu,
  output logic                    is_R_type,
  output logic                    is_I_type,
  output logic                    is_J_type,
  output logic                    is_write_from_mem,
  output logic [1:0]              control_mux_for_PC,
  output logic                    is_nop,
  output logic                    halted
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]             retired_cnt,
  output logic [31:0]             stall_cnt
`endif
);

  localparam int CNT_W = $clog2(STALL_LIMIT + 1);
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_LIMIT - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_stall_cnt;
  logic [5:0]              r_opcode;
  logic [5:0]              r_funct;
  logic                    r_is_r;
  logic                    r_is_i;
  logic                    r_is_j;

  logic [5:0]              w_dec_opcode;
  logic [5:0]              w_dec_funct;
  logic                    w_is_r;
  logic                    w_is_i;
  logic                    w_is_j;
  logic                    w_legal;
  logic [ALU_OP_WIDTH-1:0] w_alu_op;

  logic                    w_load_pc;
  logic [1:0]              w_pc_src;
  logic                    w_wr_reg;
  logic                    w_wr_mem;
  logic                    w_from_mem;
  logic [ALU_OP_WIDTH-1:0] w_alu;
  logic                    w_nop;

  // The live instruction is decoded while in DECODE; the latched copy afterwards
  assign w_dec_opcode = (r_state == DECODE) ? opcode : r_opcode;
  assign w_dec_funct  = (r_state == DECODE) ? funct  : r_funct;

  ctrl_decode #(
    .ALU_OP_WIDTH(ALU_OP_WIDTH)
  ) u_decode (
    .i_opcode (w_dec_opcode),
    .i_funct  (w_dec_funct),
    .o_is_r   (w_is_r),
    .o_is_i   (w_is_i),
    .o_is_j   (w_is_j),
    .o_legal  (w_legal),
    .o_alu_op (w_alu_op)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= FETCH;
      r_stall_cnt <= '0;
      r_is_r      <= 1'b0;
      r_is_i      <= 1'b0;
      r_is_j      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == STALL && w_state_nxt == STALL)
        r_stall_cnt <= r_stall_cnt + 1'b1;
      else
        r_stall_cnt <= '0;
      if (r_state == DECODE) begin
        r_is_r <= w_is_r;
        r_is_i <= w_is_i;
        r_is_j <= w_is_j;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == DECODE) begin
      r_opcode <= opcode;
      r_funct  <= funct;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_pc   = 1'b0;
    w_pc_src    = PC_SRC_INC;
    w_wr_reg    = 1'b0;
    w_wr_mem    = 1'b0;
    w_from_mem  = 1'b0;
    w_alu       = '0;
    w_nop       = 1'b0;
    unique case (r_state)
      FETCH: w_state_nxt = DECODE;
      DECODE: begin
        if (!w_legal) begin
          w_state_nxt = HALT;
        end else if (opcode == OP_NOP) begin
          w_load_pc   = 1'b1;
          w_pc_src    = PC_SRC_INC;
          w_state_nxt = FETCH;
        end else if (opcode == OP_J) begin
          w_load_pc   = 1'b1;
          w_pc_src    = PC_SRC_ADDR;
          w_state_nxt = FETCH;
        end else if (hazard_hit(opcode, is_full_rnum1, is_full_rnum2)) begin
          w_state_nxt = STALL;
        end else begin
          w_state_nxt = EXEC;
        end
      end
      STALL: begin
        w_nop = 1'b1;
        // A cleared hazard wins over the limit on the same cycle
        if (!hazard_hit(r_opcode, is_full_rnum1, is_full_rnum2))
          w_state_nxt = EXEC;
        else if (r_stall_cnt >= STALL_LAST)
          w_state_nxt = HALT;
      end
      EXEC: begin
        w_alu = w_alu_op;
        if (r_opcode == OP_BEQ) begin
          w_load_pc   = 1'b1;
          w_pc_src    = is_alu_zero ? PC_SRC_IMM : PC_SRC_INC;
          w_state_nxt = FETCH;
        end else if (r_opcode == OP_LW || r_opcode == OP_SW) begin
          w_state_nxt = MEM;
        end else begin
          w_state_nxt = WB;
        end
      end
      MEM: begin
        w_alu = w_alu_op;
        if (r_opcode == OP_SW) begin
          w_wr_mem    = 1'b1;
          w_load_pc   = 1'b1;
          w_state_nxt = FETCH;
        end else begin
          w_state_nxt = WB;
        end
      end
      WB: begin
        w_alu       = w_alu_op;
        w_wr_reg    = 1'b1;
        w_load_pc   = 1'b1;
        w_from_mem  = (r_opcode == OP_LW);
        w_state_nxt = FETCH;
      end
      HALT: w_state_nxt = HALT;
      default: w_state_nxt = FETCH;
    endcase
  end

  assign is_load_PC         = w_load_pc;
  assign is_write_reg       = w_wr_reg;
  assign is_write_mem       = w_wr_mem;
  assign opcode_alu         = w_alu;
  assign is_R_type          = r_is_r;
  assign is_I_type          = r_is_i;
  assign is_J_type          = r_is_j;
  assign is_write_from_mem  = w_from_mem;
  assign control_mux_for_PC = w_pc_src;
  assign is_nop             = w_nop;
  assign halted             = (r_state == HALT);

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] r_retired_cnt;
  logic [31:0] r_stall_cnt_perf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_retired_cnt    <= '0;
      r_stall_cnt_perf <= '0;
    end else begin
      if (w_load_pc)
        r_retired_cnt <= r_retired_cnt + 32'd1;
      if (r_state == STALL)
        r_stall_cnt_perf <= r_stall_cnt_perf + 32'd1;
    end
  end

  assign retired_cnt = r_retired_cnt;
  assign stall_cnt   = r_stall_cnt_perf;
`endif

endmodule

// File: tb/tb_control_fsm_cpu.sv
// Scoreboard bench for control_fsm_cpu: a transaction-level model predicts every
// strobe/stall/halt event by cycle; a monitor pops and compares on each DUT event.
module tb_control_fsm_cpu;

  localparam int LIMIT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic        is_alu_zero = 1'b0;
  logic        is_full_rnum1 = 1'b0;
  logic        is_full_rnum2 = 1'b0;
  logic        is_load_PC, is_write_reg, is_write_mem, is_write_from_mem;
  logic [5:0]  opcode_alu;
  logic        is_R_type, is_I_type, is_J_type, is_nop, halted;
  logic [1:0]  control_mux_for_PC;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] retired_cnt, stall_cnt;
`endif

  control_fsm_cpu #(.STALL_LIMIT(LIMIT), .ALU_OP_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .is_alu_zero(is_alu_zero), .is_full_rnum1(is_full_rnum1), .is_full_rnum2(is_full_rnum2),
    .is_load_PC(is_load_PC), .is_write_reg(is_write_reg), .is_write_mem(is_write_mem),
    .opcode_alu(opcode_alu), .is_R_type(is_R_type), .is_I_type(is_I_type),
    .is_J_type(is_J_type), .is_write_from_mem(is_write_from_mem),
    .control_mux_for_PC(control_mux_for_PC), .is_nop(is_nop), .halted(halted)
`ifdef CTRL_PERF_CNT_EN
    , .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event vector: {load, mux[1:0], wreg, wmem, fmem, alu[5:0], R, I, J, nop, halt_rise}
  typedef struct {
    int         c;
    logic [16:0] v;
  } ev_t;

  ev_t        exp_q[$];
  int         checks = 0;
  int         failures = 0;
  logic       done = 1'b0;
  logic [2:0] m_flags = 3'b000;

  function automatic logic [16:0] mk(input logic ld, input logic [1:0] mx, input logic wr,
                                     input logic wm, input logic fm, input logic [5:0] al,
                                     input logic [2:0] fl, input logic np, input logic hl);
    return {ld, mx, wr, wm, fm, al, fl, np, hl};
  endfunction

  function automatic void push(input int c, input logic [16:0] v);
    ev_t e;
    e.c = c;
    e.v = v;
    exp_q.push_back(e);
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return op == 6'h00 || op == 6'h08 || op == 6'h23 || op == 6'h2B ||
           op == 6'h04 || op == 6'h02 || op == 6'h3F;
  endfunction

  // Instruction-level reference: called during the FETCH cycle, returns in the next FETCH
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input logic h1, input logic h2, input int hl);
    int         f, s, e, end_c;
    logic [2:0] nfl;
    logic [5:0] alu;
    logic       rel, stop;
    f = cyc;
    opcode = op;
    funct = fn;
    is_alu_zero = z;
    is_full_rnum1 = h1 && hl > 0;
    is_full_rnum2 = h2 && hl > 0;
    stop = 1'b0;
    s = 0;
    nfl = (op == 6'h00) ? 3'b100 :
          (op == 6'h08 || op == 6'h23 || op == 6'h2B || op == 6'h04) ? 3'b010 :
          (op == 6'h02) ? 3'b001 : 3'b000;
    alu = (op == 6'h00) ? fn : (op == 6'h04) ? 6'h22 : 6'h20;
    if (!is_legal(op)) begin
      push(f + 2, mk(0, 2'd0, 0, 0, 0, 6'h00, 3'b000, 0, 1));
      m_flags = 3'b000;
      stop = 1'b1;
      end_c = f + 6;
    end else if (op == 6'h3F || op == 6'h02) begin
      push(f + 1, mk(1, (op == 6'h02) ? 2'd2 : 2'd0, 0, 0, 0, 6'h00, m_flags, 0, 0));
      m_flags = nfl;
      end_c = f + 2;
    end else begin
      m_flags = nfl;
      rel = (op == 6'h00 || op == 6'h04 || op == 6'h2B) ? (h1 | h2) : h1;
      if (rel && hl > 0) begin
        s = (hl > LIMIT) ? LIMIT : hl;
        for (int k = 1; k <= s; k++)
          push(f + 1 + k, mk(0, 2'd0, 0, 0, 0, 6'h00, nfl, 1, 0));
        if (hl > LIMIT) begin
          push(f + 2 + LIMIT, mk(0, 2'd0, 0, 0, 0, 6'h00, nfl, 0, 1));
          stop = 1'b1;
        end
      end
      e = f + 2 + s;
      end_c = stop ? f + LIMIT + 6 : e + 2;
      if (!stop) begin
        if (op == 6'h04) begin
          push(e, mk(1, z ? 2'd1 : 2'd0, 0, 0, 0, alu, nfl, 0, 0));
          end_c = e + 1;
        end else if (op == 6'h2B) begin
          push(e + 1, mk(1, 2'd0, 0, 1, 0, alu, nfl, 0, 0));
        end else if (op == 6'h23) begin
          push(e + 2, mk(1, 2'd0, 1, 0, 1, alu, nfl, 0, 0));
          end_c = e + 3;
        end else begin
          push(e + 1, mk(1, 2'd0, 1, 0, 0, alu, nfl, 0, 0));
        end
      end
    end
    while (cyc < end_c) begin
      @(posedge clk);
      #1;
      if (cyc > f + hl) begin
        is_full_rnum1 = 1'b0;
        is_full_rnum2 = 1'b0;
      end
    end
    if (stop) do_reset();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    is_full_rnum1 = 1'b0;
    is_full_rnum2 = 1'b0;
    m_flags = 3'b000;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
  endtask

  // SW aborted by reset in its MEM cycle: no write strobe may appear
  task automatic sw_abort();
    opcode = 6'h2B;
    funct = 6'h00;
    is_full_rnum1 = 1'b0;
    is_full_rnum2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_reset();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    run_instr(6'h00, 6'h20, 0, 0, 0, 0);
    run_instr(6'h23, 6'h00, 0, 0, 0, 0);
    run_instr(6'h04, 6'h00, 1, 0, 0, 0);
    run_instr(6'h04, 6'h00, 0, 0, 0, 0);
    run_instr(6'h00, 6'h20, 0, 0, 1, 3);
    run_instr(6'h08, 6'h00, 0, 0, 1, 4);
    run_instr(6'h02, 6'h00, 0, 1, 1, 2);
    run_instr(6'h3F, 6'h00, 0, 0, 0, 0);
    run_instr(6'h2B, 6'h00, 0, 1, 0, LIMIT);
    run_instr(6'h00, 6'h22, 0, 0, 1, 20);
    run_instr(6'h11, 6'h00, 0, 0, 0, 0);
    sw_abort();
    run_instr(6'h2B, 6'h00, 0, 0, 0, 0);
    for (int n = 0; n < 250; n++) begin
      int          sel, hv, hl;
      logic [5:0]  op;
      sel = $urandom_range(0, 39);
      if (sel < 7)       op = 6'h00;
      else if (sel < 12) op = 6'h08;
      else if (sel < 17) op = 6'h23;
      else if (sel < 22) op = 6'h2B;
      else if (sel < 29) op = 6'h04;
      else if (sel < 33) op = 6'h02;
      else if (sel < 38) op = 6'h3F;
      else begin
        op = 6'($urandom_range(0, 63));
        while (is_legal(op)) op = 6'($urandom_range(0, 63));
      end
      hv = $urandom_range(0, 19);
      hl = (hv < 12) ? 0 : (hv < 18) ? $urandom_range(1, 4) : $urandom_range(12, 18);
      run_instr(op, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), hl);
    end
    repeat (3) @(posedge clk);
    done = 1'b1;
  end

  initial begin : monitor
    logic        prev_halt;
    logic        trig;
    logic [16:0] act;
    ev_t         e;
    prev_halt = 1'b0;
    forever begin
      @(negedge clk);
      if (done) break;
      if (!rst) begin
        prev_halt = 1'b0;
        checks++;
        if ({is_load_PC, control_mux_for_PC, is_write_reg, is_write_mem, is_write_from_mem,
             opcode_alu, is_R_type, is_I_type, is_J_type, is_nop, halted} != 17'h0) begin
          failures++;
          $display("FAIL reset_outputs cyc=%0d got=%h expected=0", cyc,
                   {is_load_PC, control_mux_for_PC, is_write_reg, is_write_mem, is_write_from_mem,
                    opcode_alu, is_R_type, is_I_type, is_J_type, is_nop, halted});
        end
      end else begin
        while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
          checks++;
          failures++;
          $display("FAIL missing_event cyc=%0d got=none expected=%h@%0d", cyc, exp_q[0].v, exp_q[0].c);
          void'(exp_q.pop_front());
        end
        act = {is_load_PC, control_mux_for_PC, is_write_reg, is_write_mem, is_write_from_mem,
               opcode_alu, is_R_type, is_I_type, is_J_type, is_nop, halted & ~prev_halt};
        trig = is_load_PC | is_write_reg | is_write_mem | is_write_from_mem | is_nop |
               (control_mux_for_PC != 2'd0) | (halted & ~prev_halt);
        if (trig) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event cyc=%0d got=%h expected=none", cyc, act);
          end else begin
            e = exp_q.pop_front();
            if (e.c != cyc || e.v != act) begin
              failures++;
              $display("FAIL event cyc=%0d got=%h expected=%h@%0d", cyc, act, e.v, e.c);
            end
          end
        end
        prev_halt = halted;
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_events got=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_fsm_cpu.md
Name: control_fsm_cpu

Overview:
Multicycle control unit that drives the CPU datapath's control inputs. It sits directly upstream of the datapath and consumes the datapath's decode and status outputs: opcode, funct, is_alu_zero, is_full_rnum1 and is_full_rnum2. It sequences each instruction through fetch, decode, execute, memory and writeback states. It stalls on register hazards and halts on an illegal opcode.

Parameters:
STALL_LIMIT, 15, maximum consecutive hazard-stall cycles before entering HALT; must be ≥ 1.
ALU_OP_WIDTH, 6, width of the opcode_alu output.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset; asynchronous, active-low.
opcode  in  6  instruction[31:26] from the datapath.
funct  in  6  instruction[5:0] from the datapath.
is_alu_zero  in  1  ALU zero flag.
is_full_rnum1  in  1  rs has a write pending.
is_full_rnum2  in  1  rt has a write pending.
is_load_PC  out  1  PC load strobe.
is_write_reg  out  1  register file write enable.
is_write_mem  out  1  data memory write enable.
opcode_alu  out  ALU_OP_WIDTH  ALU operation select.
is_R_type  out  1  current instruction is R-type.
is_I_type  out  1  current instruction is I-type.
is_J_type  out  1  current instruction is J-type.
is_write_from_mem  out  1  writeback data source is memory.
control_mux_for_PC  out  2  PC source: 0 = PC+1, 1 = PC+IMM, 2 = ADDR.
is_nop  out  1  bubble indicator to the hazard tracker.
halted  out  1  HALT state reached.

Behaviour:
- Reset (rst = 0, asynchronous): state = FETCH, stall counter = 0. Every output is 0; opcode_alu = 0; control_mux_for_PC = 0.
- Decoded opcodes:
  - 0x00 R-type.
  - 0x08 ADDI.
  - 0x23 LW.
  - 0x2B SW.
  - 0x04 BEQ.
  - 0x02 J.
  - 0x3F NOP.
  - Any other value is illegal.
- ALU operation codes (ALU_ADD = 0x20, ALU_SUB = 0x22):
  - R-type: opcode_alu = funct.
  - ADDI, LW, SW: opcode_alu = ALU_ADD.
  - BEQ: opcode_alu = ALU_SUB.
  - Otherwise: 0.
- FETCH: lasts one cycle, then go to DECODE.
- DECODE:
  - Latch opcode and funct into internal registers. All later states use the latched copies.
  - Set the type flags from the latched opcode: is_R_type for R; is_I_type for ADDI, LW, SW, BEQ; is_J_type for J. The flags hold until the next DECODE.
  - Illegal opcode: go to HALT.
  - NOP: is_load_PC = 1, control_mux_for_PC = 0, go to FETCH.
  - J: is_load_PC = 1, control_mux_for_PC = 2, go to FETCH.
  - Hazard: R/BEQ/SW with is_full_rnum1 | is_full_rnum2, or ADDI/LW with is_full_rnum1 → STALL.
  - Otherwise: go to EXEC.
- STALL:
  - is_nop = 1 every cycle; the stall counter increments.
  - When the hazard clears, return to EXEC.
  - If the counter reaches STALL_LIMIT, go to HALT.
  - The counter clears on leaving STALL.
- EXEC:
  - opcode_alu is driven.
  - BEQ: is_load_PC = 1; control_mux_for_PC = is_alu_zero ? 1 : 0; go to FETCH.
  - LW and SW: go to MEM.
  - R and ADDI: go to WB.
- MEM:
  - SW: is_write_mem = 1, is_load_PC = 1, control_mux_for_PC = 0, go to FETCH.
  - LW: go to WB.
- WB:
  - is_write_reg = 1, is_load_PC = 1, control_mux_for_PC = 0.
  - is_write_from_mem = 1 for LW only.
  - Go to FETCH.
- HALT: absorbing. halted = 1; all strobes are 0. Only reset exits.
- Latencies in cycles from FETCH to the next FETCH: J and NOP 2; BEQ 3; R, ADDI and SW 4; LW 5. Each stall cycle adds 1.
- Strobes are asserted for exactly one cycle. is_write_reg and is_write_mem are never asserted together.
- opcode_alu is held through MEM and WB.
- Reset asserted mid-instruction aborts it immediately; no strobe is emitted afterward.

Optional Feature:
- Macro: CTRL_PERF_CNT_EN.
- Defined:
  - Adds outputs retired_cnt[31:0] and stall_cnt[31:0].
  - retired_cnt increments each cycle is_load_PC = 1.
  - stall_cnt increments each STALL cycle.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: these ports and the counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package ctrl_pkg holds:
  - the state enum (FETCH, DECODE, STALL, EXEC, MEM, WB, HALT);
  - the opcode constants;
  - ALU_ADD and ALU_SUB;
  - the PC_SRC_* encodings 0/1/2.
- One sub-module, ctrl_decode: a combinational map from the latched opcode to the type flags, the alu op and the legal bit.

Test Plan:
- R-type ADD (opcode 0, funct 0x20), no hazards → opcode_alu = 0x20 in EXEC. is_write_reg = 1 and is_load_PC = 1 in cycle 4. Next FETCH in cycle 5.
- LW (0x23) → is_write_from_mem = 1 together with is_write_reg in cycle 5. is_write_mem stays 0 throughout.
- BEQ with is_alu_zero = 1 → control_mux_for_PC = 1 with is_load_PC in cycle 3. Repeat with zero = 0 → control_mux_for_PC = 0.
- ADD with is_full_rnum2 = 1 for 3 cycles → is_nop high for exactly 3 cycles, then EXEC. Total latency is 7 cycles.
- Hazard held with STALL_LIMIT = 15 → halted = 1 after 15 stall cycles. Illegal opcode 0x11 → halted = 1 on the cycle after DECODE.
- Drive rst = 0 during MEM of SW → is_write_mem never asserts. After release the FSM resumes in FETCH.
